// File: rtl/register_scheduler_pkg.sv
// Shared types and sizing constants for the register scheduler:
// issue/writeback bundles and the register file write port.
package register_scheduler_pkg;

    localparam int NREG_C = 32;
    localparam int CNTW_C = 2;
    localparam int XLEN_C = 32;
    localparam int AW_C   = $clog2(NREG_C);

    typedef struct packed {
        logic              wren;
        logic [AW_C-1:0]   waddr;
        logic [XLEN_C-1:0] wdata;
    } register_write_in_type;

    typedef struct packed {
        logic            valid;
        logic            rden1;
        logic [AW_C-1:0] raddr1;
        logic            rden2;
        logic [AW_C-1:0] raddr2;
        logic            wren;
        logic [AW_C-1:0] waddr;
    } scheduler_issue_in_type;

    typedef struct packed {
        logic              valid;
        logic [AW_C-1:0]   waddr;
        logic [XLEN_C-1:0] wdata;
    } writeback_in_type;

    typedef struct packed {
        logic ready;
    } writeback_out_type;

    typedef struct packed {
        logic              iss_stall;
        logic [NREG_C-1:0] busy_vec;
    } scheduler_out_type;

endpackage

// File: rtl/register_wb_arbiter.sv
// Two-way round-robin arbiter for the register file write port
// with the registered write-port output.
import register_scheduler_pkg::*;

module register_wb_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    input  writeback_in_type      wb0_i,
    input  writeback_in_type      wb1_i,
    output writeback_out_type     wb0_o,
    output writeback_out_type     wb1_o,
    output register_write_in_type win_o
);

    logic                  last_q, last_d;
    register_write_in_type win_q, win_d;
    logic                  gnt0, gnt1;

    // last_q names the most recent winner; the other side wins a tie.
    assign gnt0 = wb0_i.valid && (!wb1_i.valid || last_q);
    assign gnt1 = wb1_i.valid && (!wb0_i.valid || !last_q);

    assign wb0_o.ready = gnt0;
    assign wb1_o.ready = gnt1;
    assign win_o       = win_q;

    always_comb begin
        last_d     = last_q;
        win_d      = win_q;
        win_d.wren = 1'b0;
        if (gnt0) begin
            last_d = 1'b0;
            win_d  = '{wren: wb0_i.waddr != '0,
                       waddr: wb0_i.waddr,
                       wdata: wb0_i.wdata};
        end else if (gnt1) begin
            last_d = 1'b1;
            win_d  = '{wren: wb1_i.waddr != '0,
                       waddr: wb1_i.waddr,
                       wdata: wb1_i.wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
            win_q  <= '0;
        end else begin
            last_q <= last_d;
            win_q  <= win_d;
        end
    end

endmodule

// File: rtl/register_scheduler.sv
// Pending-write scoreboard with issue stall, plus the writeback
// arbiter feeding the shared integer register file write port.
import register_scheduler_pkg::*;

module register_scheduler #(
    parameter int NREG = NREG_C,
    parameter int XLEN = XLEN_C,
    parameter int CNTW = CNTW_C,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic                  iss_rden1,
    input  logic [AW-1:0]         iss_raddr1,
    input  logic                  iss_rden2,
    input  logic [AW-1:0]         iss_raddr2,
    input  logic                  iss_wren,
    input  logic [AW-1:0]         iss_waddr,
    output logic                  iss_stall,
    input  logic                  wb0_valid,
    input  logic [AW-1:0]         wb0_waddr,
    input  logic [XLEN-1:0]       wb0_wdata,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [AW-1:0]         wb1_waddr,
    input  logic [XLEN-1:0]       wb1_wdata,
    output logic                  wb1_ready,
    output register_write_in_type register_win,
    output logic [NREG-1:0]       busy_vec
);

    scheduler_issue_in_type iss;
    scheduler_out_type      sch;
    writeback_in_type       wb0_in, wb1_in;
    writeback_out_type      wb0_out, wb1_out;

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];
    logic            raw1, raw2, wawsat, accept;

    assign iss = '{valid: iss_valid,
                   rden1: iss_rden1, raddr1: iss_raddr1,
                   rden2: iss_rden2, raddr2: iss_raddr2,
                   wren: iss_wren, waddr: iss_waddr};

    assign wb0_in = '{valid: wb0_valid, waddr: wb0_waddr, wdata: wb0_wdata};
    assign wb1_in = '{valid: wb1_valid, waddr: wb1_waddr, wdata: wb1_wdata};

    // Conservative: a commit in this cycle does not clear a hazard yet.
    assign raw1   = iss.rden1 && iss.raddr1 != '0 && cnt_q[iss.raddr1] != '0;
    assign raw2   = iss.rden2 && iss.raddr2 != '0 && cnt_q[iss.raddr2] != '0;
    assign wawsat = iss.wren && iss.waddr != '0 && cnt_q[iss.waddr] == '1;
    assign accept = iss.valid && !sch.iss_stall && iss.wren && iss.waddr != '0;

    always_comb begin
        sch.iss_stall = iss.valid && (raw1 || raw2 || wawsat);
        sch.busy_vec  = '0;
        for (int i = 1; i < NREG; i++) begin
            sch.busy_vec[i] = cnt_q[i] != '0;
        end
    end

    assign iss_stall = sch.iss_stall;
    assign busy_vec  = sch.busy_vec;
    assign wb0_ready = wb0_out.ready;
    assign wb1_ready = wb1_out.ready;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 1; i < NREG; i++) begin
            if (accept && iss.waddr == AW'(i)
                && !(register_win.wren && register_win.waddr == AW'(i))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!(accept && iss.waddr == AW'(i))
                && register_win.wren && register_win.waddr == AW'(i)
                && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            assert (!(register_win.wren && register_win.waddr != '0
                      && cnt_q[register_win.waddr] == '0
                      && !(accept && iss.waddr == register_win.waddr)))
                else $error("commit to register with no pending write");
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    register_wb_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .wb0_i (wb0_in),
        .wb1_i (wb1_in),
        .wb0_o (wb0_out),
        .wb1_o (wb1_out),
        .win_o (register_win)
    );

endmodule

// File: tb/tb_register_scheduler.sv
// Randomized and directed bench for register_scheduler against
// a per-register pending-count reference model.
import register_scheduler_pkg::*;

module tb_register_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid = 0, iss_rden1 = 0, iss_rden2 = 0, iss_wren = 0;
    logic [4:0]  iss_raddr1 = 0, iss_raddr2 = 0, iss_waddr = 0;
    logic        iss_stall;
    logic        wb0_valid = 0, wb1_valid = 0;
    logic [4:0]  wb0_waddr = 0, wb1_waddr = 0;
    logic [31:0] wb0_wdata = 0, wb1_wdata = 0;
    logic        wb0_ready, wb1_ready;
    register_write_in_type register_win;
    logic [31:0] busy_vec;

    int n_vec = 0;
    int n_err = 0;

    int         pend [32];
    int         owed [$];
    bit         ew_en;
    logic [4:0] ew_a;
    logic [31:0] ew_d;
    bit         mlast;
    int         seen0, seen1;

    register_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rden1    (iss_rden1),
        .iss_raddr1   (iss_raddr1),
        .iss_rden2    (iss_rden2),
        .iss_raddr2   (iss_raddr2),
        .iss_wren     (iss_wren),
        .iss_waddr    (iss_waddr),
        .iss_stall    (iss_stall),
        .wb0_valid    (wb0_valid),
        .wb0_waddr    (wb0_waddr),
        .wb0_wdata    (wb0_wdata),
        .wb0_ready    (wb0_ready),
        .wb1_valid    (wb1_valid),
        .wb1_waddr    (wb1_waddr),
        .wb1_wdata    (wb1_wdata),
        .wb1_ready    (wb1_ready),
        .register_win (register_win),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        owed.delete();
        ew_en = 0; ew_a = 0; ew_d = 0; mlast = 1;
        wb0_valid = 0; wb1_valid = 0;
        iss_valid = 0; iss_wren = 0; iss_rden1 = 0; iss_rden2 = 0;
    endtask

    task automatic load_req(input int which, input logic [4:0] a,
                            input logic [31:0] d);
        for (int i = 0; i < owed.size(); i++) begin
            if (owed[i] == int'(a) && a != 0) begin
                owed.delete(i);
                break;
            end
        end
        if (which == 0) begin
            wb0_valid = 1; wb0_waddr = a; wb0_wdata = d;
        end else begin
            wb1_valid = 1; wb1_waddr = a; wb1_wdata = d;
        end
    endtask

    task automatic step(input bit v, input bit r1e, input logic [4:0] r1,
                        input bit r2e, input logic [4:0] r2,
                        input bit we, input logic [4:0] wa);
        bit          es, g0, g1;
        logic [31:0] eb;
        iss_valid = v; iss_rden1 = r1e; iss_raddr1 = r1;
        iss_rden2 = r2e; iss_raddr2 = r2; iss_wren = we; iss_waddr = wa;
        #1;
        es = v && ((r1e && r1 != 0 && pend[r1] > 0)
                || (r2e && r2 != 0 && pend[r2] > 0)
                || (we && wa != 0 && pend[wa] >= 3));
        g0 = wb0_valid && (!wb1_valid || mlast);
        g1 = wb1_valid && (!wb0_valid || !mlast);
        eb = '0;
        for (int i = 1; i < 32; i++) eb[i] = pend[i] > 0;
        chk("stall", 64'(iss_stall), 64'(es));
        chk("wb0_ready", 64'(wb0_ready), 64'(g0));
        chk("wb1_ready", 64'(wb1_ready), 64'(g1));
        chk("register_win", 64'(register_win), 64'({ew_en, ew_a, ew_d}));
        chk("busy_vec", 64'(busy_vec), 64'(eb));
        @(posedge clk);
        #1;
        if (ew_en) pend[ew_a]--;
        if (v && !es && we && wa != 0) begin
            pend[wa]++;
            owed.push_back(int'(wa));
        end
        if (g0) begin
            ew_en = wb0_waddr != 0; ew_a = wb0_waddr; ew_d = wb0_wdata;
            mlast = 0; wb0_valid = 0; seen0++;
        end else if (g1) begin
            ew_en = wb1_waddr != 0; ew_a = wb1_waddr; ew_d = wb1_wdata;
            mlast = 1; wb1_valid = 0; seen1++;
        end else begin
            ew_en = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((owed.size() > 0 || wb0_valid || wb1_valid || ew_en) && n < 300) begin
            if (!wb0_valid && owed.size() > 0)
                load_req(0, 5'(owed[0]), $urandom);
            if (!wb1_valid && owed.size() > 0)
                load_req(1, 5'(owed[0]), $urandom);
            idle();
            n++;
        end
        chk("drain_timeout", 64'(n < 300), 64'd1);
    endtask

    initial begin
        model_reset();
        seen0 = 0; seen1 = 0;
        #1;
        chk("reset_win", 64'(register_win), 64'd0);
        chk("reset_busy", 64'(busy_vec), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // RAW on x5, resolved by a wb0 write
        step(1, 0, 0, 0, 0, 1, 5);
        step(1, 1, 5, 0, 0, 0, 0);
        load_req(0, 5, 32'hDEADBEEF);
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0);
        chk("win_deadbeef", 64'(register_win.wdata), 64'hDEADBEEF);
        step(1, 1, 5, 0, 0, 0, 0);

        // contention alternates between requesters
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0, 0, 1, 3);
            step(1, 0, 0, 0, 0, 1, 4);
        end
        seen0 = 0; seen1 = 0;
        for (int k = 0; k < 4; k++) begin
            if (!wb0_valid) load_req(0, 3, $urandom);
            if (!wb1_valid) load_req(1, 4, $urandom);
            idle();
        end
        chk("alternate", 64'({seen0, seen1}), {32'd2, 32'd2});
        wb0_valid = 0; wb1_valid = 0;
        drain();

        // x0 destination
        step(1, 1, 0, 0, 0, 1, 0);
        load_req(1, 0, 32'h12345678);
        idle(); idle();

        // saturation at three outstanding writes
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 1, 7);
        load_req(0, 7, $urandom);
        step(1, 0, 0, 0, 0, 1, 7);
        step(1, 0, 0, 0, 0, 1, 7);
        step(1, 0, 0, 0, 0, 1, 7);
        chk("sat_recount", 64'(pend[7]), 64'd3);
        drain();

        // commit and new issue to x9 in the same cycle
        step(1, 0, 0, 0, 0, 1, 9);
        load_req(0, 9, $urandom);
        idle();
        step(1, 0, 0, 0, 0, 1, 9);
        chk("busy9_hold", 64'(busy_vec[9]), 64'd1);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!wb0_valid && owed.size() > 0 && $urandom_range(2) == 0)
                load_req(0, 5'(owed[$urandom_range(owed.size() - 1)]), $urandom);
            else if (!wb0_valid && $urandom_range(39) == 0)
                load_req(0, 0, $urandom);
            if (!wb1_valid && owed.size() > 0 && $urandom_range(3) == 0)
                load_req(1, 5'(owed[$urandom_range(owed.size() - 1)]), $urandom);
            else if (!wb1_valid && $urandom_range(39) == 0)
                load_req(1, 0, $urandom);
            step($urandom_range(9) < 7, 1'($urandom), 5'($urandom_range(7)),
                 1'($urandom), 5'($urandom_range(7)),
                 $urandom_range(3) != 0, 5'($urandom_range(7)));
        end
        drain();

        // asynchronous reset with a write in flight
        step(1, 0, 0, 0, 0, 1, 12);
        step(1, 0, 0, 0, 0, 1, 13);
        load_req(0, 12, 32'hCAFEF00D);
        idle();
        chk("pre_rst_wren", 64'(register_win.wren), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_wren", 64'(register_win.wren), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold", 64'(register_win), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
